aha_four_phase_req_ctrl: RTL and testbench

- Requester side of a four-phase REQ/ACK handshake with a peer in another clock domain.
- REQ is a registered level that goes straight to the peer.
- The peer's ACK comes back through the async pulse generator, which synchronises it and splits it into one-cycle rise and fall pulses consumed here.
- The block queues start requests, sequences the handshakes, flags timeouts and protocol errors, and holds an error state until software clears it.

---
 rtl/aha_four_phase_req_ctrl_if.sv | 28 ++
 rtl/aha_four_phase_req_ctrl.sv | 136 +++++++++++++
 tb/tb_aha_four_phase_req_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aha_four_phase_req_ctrl_if.sv
// Handshake-side signal bundle for the four-phase requester controller.
// master is the controller itself; slave is whatever drives START/CLR and the ACK edge pulses.
interface aha_four_phase_req_ctrl_if #(
   parameter int unsigned CNT_W = 4
);
   logic             START;
   logic             CLR;
   logic             ACK_RISE;
   logic             ACK_FALL;
   logic             REQ;
   logic             BUSY;
   logic             DONE;
   logic             TIMEOUT;
   logic             PROTO_ERR;
   logic             OVERFLOW;
   logic [CNT_W-1:0] PENDING;
   logic [1:0]       STATE;

   modport master (
      input  START, CLR, ACK_RISE, ACK_FALL,
      output REQ, BUSY, DONE, TIMEOUT, PROTO_ERR, OVERFLOW, PENDING, STATE
   );

   modport slave (
      output START, CLR, ACK_RISE, ACK_FALL,
      input  REQ, BUSY, DONE, TIMEOUT, PROTO_ERR, OVERFLOW, PENDING, STATE
   );
endinterface

// File: rtl/aha_four_phase_req_ctrl.sv
// Requester side of a four-phase REQ/ACK handshake: queues starts, sequences handshakes,
// flags timeouts and out-of-order ACK edges, and parks in ERROR until cleared.
module aha_four_phase_req_ctrl #(
   parameter int unsigned CNT_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_W           = 16
) (
   input logic                      CLK,
   input logic                      RESET,
   aha_four_phase_req_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWaitHi = 2'd1,
      StWaitLo = 2'd2,
      StError  = 2'd3
   } state_e;

   localparam bit               TimeoutEn = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] PendMax   = '1;
   localparam logic [TO_W-1:0]  CntMax    = '1;
   // Last cycle in which the expected edge may still arrive.
   localparam logic [TO_W-1:0]  ToLast    = TimeoutEn ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             to_q, to_d;
   logic             perr_q, perr_d;
   logic             ovf_q, ovf_d;
   logic             in_wait;
   logic             both_edges;

   assign in_wait    = (state_q == StWaitHi) || (state_q == StWaitLo);
   assign both_edges = bus.ACK_RISE && bus.ACK_FALL;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      to_d    = 1'b0;
      perr_d  = 1'b0;
      ovf_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.START || (pend_q != '0)) begin
               state_d = StWaitHi;
               if (!bus.START) pend_d = pend_q - CNT_W'(1);
            end
         end
         StWaitHi: begin
            if (both_edges || bus.ACK_FALL) begin
               perr_d = 1'b1;
            end else if (bus.ACK_RISE) begin
               state_d = StWaitLo;
            end
         end
         StWaitLo: begin
            if (both_edges || bus.ACK_RISE) begin
               perr_d = 1'b1;
            end else if (bus.ACK_FALL) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         StError: begin
            if (bus.CLR) begin
               state_d = StIdle;
               pend_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Expiry only fires when the expected edge did not move us on this cycle.
      if (TimeoutEn && in_wait && (state_d == state_q) && (cnt_q == ToLast)) begin
         state_d = StError;
         to_d    = 1'b1;
      end

      // A START alongside CLR is discarded together with the queue.
      if ((state_q != StIdle) && bus.START && !((state_q == StError) && bus.CLR)) begin
         if (pend_q == PendMax) ovf_d = 1'b1;
         else                   pend_d = pend_q + CNT_W'(1);
      end

      if (!TimeoutEn || (state_d != state_q) || !in_wait) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + TO_W'(1);
      end

      req_d  = (state_d == StWaitHi);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         pend_q  <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
         perr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         to_q    <= to_d;
         perr_q  <= perr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.REQ       = req_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.TIMEOUT   = to_q;
   assign bus.PROTO_ERR = perr_q;
   assign bus.OVERFLOW  = ovf_q;
   assign bus.PENDING   = pend_q;
   assign bus.STATE     = state_q;

endmodule

// File: tb/tb_aha_four_phase_req_ctrl.sv
// Directed bench for aha_four_phase_req_ctrl with CNT_W=2 and TIMEOUT_CYCLES=8.
module tb_aha_four_phase_req_ctrl;

   logic CLK;
   logic RESET;
   int   n_checks;
   int   n_fail;

   aha_four_phase_req_ctrl_if #(.CNT_W(2)) bus ();

   aha_four_phase_req_ctrl #(
      .CNT_W         (2),
      .TIMEOUT_CYCLES(8),
      .TO_W          (4)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic drive(input logic s, input logic c, input logic r, input logic f,
                        input logic rst);
      bus.START    = s;
      bus.CLR      = c;
      bus.ACK_RISE = r;
      bus.ACK_FALL = f;
      RESET        = rst;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      n_checks++;
      if (bus.STATE !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.STATE); end
      n_checks++;
      if ({bus.REQ, bus.BUSY, bus.DONE, bus.TIMEOUT, bus.PROTO_ERR, bus.OVERFLOW} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 000000",
                  {bus.REQ, bus.BUSY, bus.DONE, bus.TIMEOUT, bus.PROTO_ERR, bus.OVERFLOW});
      end
      n_checks++;
      if (bus.PENDING !== 2'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", bus.PENDING); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   // START at k=0, ACK_RISE at k=5, ACK_FALL at k=10; outputs observed at j=k+1.
   task automatic test_basic();
      for (int k = 0; k <= 12; k++) begin
         int j;
         int e_state;
         logic e_req, e_done;
         drive(k == 0, 1'b0, k == 5, k == 10, 1'b0);
         tick();
         j       = k + 1;
         e_req   = (j <= 5);
         e_state = (j <= 5) ? 1 : (j <= 10) ? 2 : 0;
         e_done  = (j == 11);
         n_checks++;
         if (bus.REQ !== e_req) begin n_fail++; $display("FAIL basic_req j%0d got %b want %b", j, bus.REQ, e_req); end
         n_checks++;
         if (bus.STATE !== 2'(e_state)) begin n_fail++; $display("FAIL basic_state j%0d got %0d want %0d", j, bus.STATE, e_state); end
         n_checks++;
         if (bus.DONE !== e_done) begin n_fail++; $display("FAIL basic_done j%0d got %b want %b", j, bus.DONE, e_done); end
         n_checks++;
         if (bus.PENDING !== 2'd0) begin n_fail++; $display("FAIL basic_pending j%0d got %0d want 0", j, bus.PENDING); end
         n_checks++;
         if (bus.BUSY !== (e_state != 0)) begin n_fail++; $display("FAIL basic_busy j%0d got %b want %b", j, bus.BUSY, e_state != 0); end
      end
   endtask

   task automatic test_queue();
      int st_tbl [1:12];
      int pd_tbl [1:12];
      int dones;
      st_tbl = '{1, 1, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0};
      pd_tbl = '{0, 1, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0};
      dones  = 0;
      for (int k = 0; k <= 11; k++) begin
         int j;
         logic e_done;
         drive(k <= 2, 1'b0, (k == 3) || (k == 6) || (k == 9),
               (k == 4) || (k == 7) || (k == 10), 1'b0);
         tick();
         j      = k + 1;
         e_done = (j == 5) || (j == 8) || (j == 11);
         if (bus.DONE === 1'b1) dones++;
         n_checks++;
         if (bus.STATE !== 2'(st_tbl[j])) begin n_fail++; $display("FAIL queue_state j%0d got %0d want %0d", j, bus.STATE, st_tbl[j]); end
         n_checks++;
         if (bus.PENDING !== 2'(pd_tbl[j])) begin n_fail++; $display("FAIL queue_pending j%0d got %0d want %0d", j, bus.PENDING, pd_tbl[j]); end
         n_checks++;
         if (bus.REQ !== (st_tbl[j] == 1)) begin n_fail++; $display("FAIL queue_req j%0d got %b want %b", j, bus.REQ, st_tbl[j] == 1); end
         n_checks++;
         if (bus.DONE !== e_done) begin n_fail++; $display("FAIL queue_done j%0d got %b want %b", j, bus.DONE, e_done); end
      end
      n_checks++;
      if (dones != 3) begin n_fail++; $display("FAIL queue_done_count got %0d want 3", dones); end
   endtask

   task automatic test_overflow();
      int pd_tbl [1:7];
      int ovfs;
      pd_tbl = '{0, 1, 2, 3, 3, 3, 3};
      ovfs   = 0;
      for (int k = 0; k <= 6; k++) begin
         int j;
         logic e_ovf;
         drive(k <= 5, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         j     = k + 1;
         e_ovf = (j == 5) || (j == 6);
         if (bus.OVERFLOW === 1'b1) ovfs++;
         n_checks++;
         if (bus.PENDING !== 2'(pd_tbl[j])) begin n_fail++; $display("FAIL ovf_pending j%0d got %0d want %0d", j, bus.PENDING, pd_tbl[j]); end
         n_checks++;
         if (bus.OVERFLOW !== e_ovf) begin n_fail++; $display("FAIL ovf_pulse j%0d got %b want %b", j, bus.OVERFLOW, e_ovf); end
         n_checks++;
         if (bus.STATE !== 2'd1) begin n_fail++; $display("FAIL ovf_state j%0d got %0d want 1", j, bus.STATE); end
      end
      n_checks++;
      if (ovfs != 2) begin n_fail++; $display("FAIL ovf_count got %0d want 2", ovfs); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      n_checks++;
      if ({bus.STATE, bus.PENDING} !== 4'b0) begin n_fail++; $display("FAIL ovf_reset got state %0d pending %0d want 0 0", bus.STATE, bus.PENDING); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      // No ACK: expire out of WAIT_HI, queue in ERROR, CLR with a START alongside.
      for (int k = 0; k <= 13; k++) begin
         int j;
         int e_state;
         int e_pend;
         drive((k == 0) || (k == 10) || (k == 12), k == 12, k == 11, 1'b0, 1'b0);
         tick();
         j       = k + 1;
         e_state = (j <= 8) ? 1 : (j <= 12) ? 3 : 0;
         e_pend  = (j == 11) || (j == 12) ? 1 : 0;
         n_checks++;
         if (bus.STATE !== 2'(e_state)) begin n_fail++; $display("FAIL to_state j%0d got %0d want %0d", j, bus.STATE, e_state); end
         n_checks++;
         if (bus.REQ !== (j <= 8)) begin n_fail++; $display("FAIL to_req j%0d got %b want %b", j, bus.REQ, j <= 8); end
         n_checks++;
         if (bus.TIMEOUT !== (j == 9)) begin n_fail++; $display("FAIL to_pulse j%0d got %b want %b", j, bus.TIMEOUT, j == 9); end
         n_checks++;
         if (bus.PENDING !== 2'(e_pend)) begin n_fail++; $display("FAIL to_pending j%0d got %0d want %0d", j, bus.PENDING, e_pend); end
         n_checks++;
         if (bus.PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL to_no_perr j%0d got %b want 0", j, bus.PROTO_ERR); end
         n_checks++;
         if (bus.BUSY !== (e_state != 0)) begin n_fail++; $display("FAIL to_busy j%0d got %b want %b", j, bus.BUSY, e_state != 0); end
      end
      // ACK_RISE in the last allowed cycle wins; then WAIT_LO expires with no ACK_FALL.
      for (int k = 0; k <= 18; k++) begin
         int j;
         int e_state;
         drive(k == 0, k == 18, k == 8, 1'b0, 1'b0);
         tick();
         j       = k + 1;
         e_state = (j <= 8) ? 1 : (j <= 16) ? 2 : (j <= 18) ? 3 : 0;
         n_checks++;
         if (bus.STATE !== 2'(e_state)) begin n_fail++; $display("FAIL to_last_state j%0d got %0d want %0d", j, bus.STATE, e_state); end
         n_checks++;
         if (bus.TIMEOUT !== (j == 17)) begin n_fail++; $display("FAIL to_last_pulse j%0d got %b want %b", j, bus.TIMEOUT, j == 17); end
         n_checks++;
         if (bus.REQ !== (j <= 8)) begin n_fail++; $display("FAIL to_last_req j%0d got %b want %b", j, bus.REQ, j <= 8); end
      end
   endtask

   task automatic test_proto_reset();
      int st_tbl [1:10];
      st_tbl = '{1, 1, 1, 1, 1, 2, 2, 2, 0, 0};
      for (int k = 0; k <= 9; k++) begin
         int j;
         int e_pend;
         logic e_perr;
         drive((k == 0) || (k == 7), 1'b0, (k == 4) || (k == 5) || (k == 6) || (k == 9),
               (k == 2) || (k == 4), k == 8);
         tick();
         j      = k + 1;
         e_perr = (j == 3) || (j == 5) || (j == 7);
         e_pend = (j == 8) ? 1 : 0;
         n_checks++;
         if (bus.STATE !== 2'(st_tbl[j])) begin n_fail++; $display("FAIL proto_state j%0d got %0d want %0d", j, bus.STATE, st_tbl[j]); end
         n_checks++;
         if (bus.PROTO_ERR !== e_perr) begin n_fail++; $display("FAIL proto_pulse j%0d got %b want %b", j, bus.PROTO_ERR, e_perr); end
         n_checks++;
         if (bus.PENDING !== 2'(e_pend)) begin n_fail++; $display("FAIL proto_pending j%0d got %0d want %0d", j, bus.PENDING, e_pend); end
         n_checks++;
         if (bus.REQ !== (j <= 5)) begin n_fail++; $display("FAIL proto_req j%0d got %b want %b", j, bus.REQ, j <= 5); end
         if (j >= 9) begin
            n_checks++;
            if ({bus.BUSY, bus.DONE, bus.TIMEOUT, bus.OVERFLOW} !== 4'b0) begin
               n_fail++;
               $display("FAIL proto_reset_flags j%0d got %b want 0000", j,
                        {bus.BUSY, bus.DONE, bus.TIMEOUT, bus.OVERFLOW});
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      test_reset();
      test_basic();
      test_queue();
      test_overflow();
      test_timeout();
      test_proto_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
